dmem_responder: RTL and testbench

- Data-memory responder on the far side of the cpu data bus. It serves the cpu's read port (raddr/re/rdata) and write port (waddr/wdata/we).
- Backs the low address range with a synchronous word RAM.
- Decodes a 0xFF00 I/O page holding a console transmit FIFO with a ready/valid drain port, a status register and an optional cycle counter.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous word RAM in the low range plus a 0xFF00 I/O page
// (console TX FIFO, status register, optional cycle counter under DMEM_CYCLE_COUNTER_EN).
module dmem_responder #(
  parameter int ADDRWIDTH  = 16,
  parameter int DWIDTH     = 16,
  parameter int RAM_AWIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] raddr,
  input  logic                 re,
  output logic [DWIDTH-1:0]    rdata,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic                 we,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0] IO_PAGE     = 8'hFF;
  localparam logic [7:0] REG_CONSOLE = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h01;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam logic [7:0] REG_CNT_LO  = 8'h02;
  localparam logic [7:0] REG_CNT_HI  = 8'h03;
`endif

  function automatic logic is_ram(input logic [ADDRWIDTH-1:0] a);
    return (a >> RAM_AWIDTH) == '0;
  endfunction

  function automatic logic is_io(input logic [ADDRWIDTH-1:0] a);
    return a[ADDRWIDTH-1 -: 8] == IO_PAGE;
  endfunction

  logic rd_ram, rd_io, rd_unm;
  logic wr_ram, wr_io, wr_unm;

  assign rd_ram = is_ram(raddr);
  assign rd_io  = is_io(raddr);
  assign rd_unm = !rd_ram && !rd_io;
  assign wr_ram = is_ram(waddr);
  assign wr_io  = is_io(waddr);
  assign wr_unm = !wr_ram && !wr_io;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop, accept;
  logic             overflow, unmapped;
  logic             stat_wr, ovf_set, unm_set;

  assign full     = count == CNT_W'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  assign push    = we && wr_io && (waddr[7:0] == REG_CONSOLE);
  assign pop     = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign accept  = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign stat_wr = we && wr_io && (waddr[7:0] == REG_STATUS);
  assign unm_set = (re && rd_unm) || (we && wr_unm);

  logic [7:0] status;
  assign status = {4'(count), unmapped, overflow, empty, full};

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] counter;
  logic [15:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      shadow  <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (re && rd_io && (raddr[7:0] == REG_CNT_LO))
        shadow <= counter[31:16];
    end
  end
`endif

  // Stage p0: combinational I/O read value from pre-edge state
  logic [DWIDTH-1:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    if (rd_io) begin
      case (raddr[7:0])
        REG_STATUS: io_rdata = DWIDTH'(status);
`ifdef DMEM_CYCLE_COUNTER_EN
        REG_CNT_LO: io_rdata = DWIDTH'(counter[15:0]);
        REG_CNT_HI: io_rdata = DWIDTH'(shadow);
`endif
        default:    io_rdata = '0;
      endcase
    end
  end

  // Stage p1: registered read data (RAM array kept reset-free for inference)
  logic [DWIDTH-1:0] ram [0:(1 << RAM_AWIDTH) - 1];
  logic [DWIDTH-1:0] ram_q_p1;
  logic [DWIDTH-1:0] io_q_p1;
  logic              sel_ram_p1;

  always_ff @(posedge clk) begin
    if (we && wr_ram)
      ram[waddr[RAM_AWIDTH-1:0]] <= wdata;
    if (re && rd_ram)
      ram_q_p1 <= ram[raddr[RAM_AWIDTH-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ram_p1 <= 1'b0;
      io_q_p1    <= '0;
    end else if (re) begin
      sel_ram_p1 <= rd_ram;
      io_q_p1    <= rd_ram ? '0 : io_rdata;
    end
  end

  assign rdata = sel_ram_p1 ? ram_q_p1 : io_q_p1;

  always_ff @(posedge clk) begin
    if (accept)
      fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      unmapped <= 1'b0;
    end else begin
      overflow <= ovf_set || (overflow && !(stat_wr && wdata[2]));
      unmapped <= unm_set || (unmapped && !(stat_wr && wdata[3]));
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps followed by random traffic
// compared against a queue/array reference model of the memory map.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] raddr = '0, waddr = '0, wdata = '0;
  logic        re = 1'b0, we = 1'b0, tx_ready = 1'b0;
  logic [15:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .raddr(raddr), .re(re), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .we(we),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] ram_m [int];
  logic [7:0]  q_m [$];
  bit          ovf_m, unm_m;
  logic [15:0] rd_m;
  logic [31:0] cnt_m;
  logic [15:0] shadow_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] status_m();
    logic [15:0] s;
    s      = '0;
    s[0]   = (q_m.size() == 4);
    s[1]   = (q_m.size() == 0);
    s[2]   = ovf_m;
    s[3]   = unm_m;
    s[7:4] = 4'(q_m.size());
    return s;
  endfunction

  function automatic logic [15:0] read_m(input logic [15:0] a);
    if (a < 16'h1000) return ram_m[int'(a)];
    if (a[15:8] == 8'hFF) begin
      case (a[7:0])
        8'h01: return status_m();
`ifdef DMEM_CYCLE_COUNTER_EN
        8'h02: return cnt_m[15:0];
        8'h03: return shadow_m;
`endif
        default: return 16'h0000;
      endcase
    end
    return 16'h0000;
  endfunction

  function automatic bit unmapped_addr(input logic [15:0] a);
    return (a >= 16'h1000) && (a[15:8] != 8'hFF);
  endfunction

  // One clock with the given port values, then advance the model and compare outputs.
  task automatic cycle(input bit r, input logic [15:0] ra, input bit w,
                       input logic [15:0] wa, input logic [15:0] wd, input bit tr);
    bit pop, push, ovf_set, unm_set, clr_ovf, clr_unm, vld;
    re = r; raddr = ra; we = w; waddr = wa; wdata = wd; tx_ready = tr;
    @(posedge clk);
    pop     = (q_m.size() > 0) && tr;
    push    = w && (wa == 16'hFF00);
    ovf_set = 1'b0;
    if (r) rd_m = read_m(ra);
`ifdef DMEM_CYCLE_COUNTER_EN
    if (r && ra == 16'hFF02) shadow_m = cnt_m[31:16];
    cnt_m = cnt_m + 32'd1;
`endif
    if (w && wa < 16'h1000) ram_m[int'(wa)] = wd;
    if (pop) void'(q_m.pop_front());
    if (push) begin
      if (q_m.size() < 4) q_m.push_back(wd[7:0]);
      else ovf_set = 1'b1;
    end
    unm_set = (r && unmapped_addr(ra)) || (w && unmapped_addr(wa));
    clr_ovf = w && (wa == 16'hFF01) && wd[2];
    clr_unm = w && (wa == 16'hFF01) && wd[3];
    ovf_m = ovf_set || (ovf_m && !clr_ovf);
    unm_m = unm_set || (unm_m && !clr_unm);
    #1;
    vld = (q_m.size() > 0);
    chk("rdata", rdata, rd_m);
    chk("tx_valid", {15'b0, tx_valid}, {15'b0, vld});
    if (vld) chk("tx_data", {8'h0, tx_data}, {8'h0, q_m[0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; re = 0; we = 0; tx_ready = 0;
    #3;
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst_tx_data", {8'h0, tx_data}, 16'h0000);
    q_m.delete();
    ovf_m = 0; unm_m = 0; rd_m = '0; cnt_m = '0; shadow_m = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_addr(input bit for_write);
    int k;
    k = $urandom_range(0, for_write ? 11 : 9);
    case (k)
      0, 1, 2, 3: begin
        k = $urandom_range(0, 16);
        return (k == 16) ? 16'h0FFF : 16'(k);
      end
      4, 10, 11: return 16'hFF00;
      5:         return 16'hFF01;
      6:         return 16'hFF02;
      7:         return 16'hFF03;
      8:         return 16'hFF00 | 16'($urandom_range(4, 255));
      default:   return 16'h1000 + 16'($urandom_range(0, 16'hEEFF));
    endcase
  endfunction

  initial begin
    #2;
    do_reset();

    // Known contents for every RAM word the random phase touches
    for (int i = 0; i < 16; i++) cycle(0, 16'h0, 1, 16'(i), 16'($urandom), 0);
    cycle(0, 16'h0, 1, 16'h0FFF, 16'($urandom), 0);

    // RAM round trip and hold
    cycle(0, 16'h0, 1, 16'h0010, 16'h1234, 0);
    cycle(1, 16'h0010, 0, 16'h0, 16'h0, 0);
    chk("ram_roundtrip", rdata, 16'h1234);
    idle(2);
    chk("ram_hold", rdata, 16'h1234);

    // Read-before-write on the same word
    cycle(0, 16'h0, 1, 16'h0020, 16'hAAAA, 0);
    cycle(1, 16'h0020, 1, 16'h0020, 16'h5555, 0);
    chk("rbw_old", rdata, 16'hAAAA);
    cycle(1, 16'h0020, 0, 16'h0, 16'h0, 0);
    chk("rbw_new", rdata, 16'h5555);

    // Fill FIFO, overflow, drain, clear overflow
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 16'hFF00, 16'h0041 + 16'(i), 0);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_full", rdata, 16'h0041);
    cycle(0, 16'h0, 1, 16'hFF00, 16'h0045, 0);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_ovf", rdata, 16'h0045);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", {8'h0, tx_data}, 16'h0041 + 16'(i));
      cycle(0, 16'h0, 0, 16'h0, 16'h0, 1);
    end
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_empty_ovf", rdata, 16'h0006);
    cycle(0, 16'h0, 1, 16'hFF01, 16'h0004, 0);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_ovf_clr", rdata, 16'h0002);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 16'hFF00, 16'h0011 + 16'(i), 0);
    cycle(0, 16'h0, 1, 16'hFF00, 16'h0055, 1);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("full_pushpop", rdata, 16'h0041);
    for (int i = 0; i < 3; i++) cycle(0, 16'h0, 0, 16'h0, 16'h0, 1);
    chk("last_byte", {8'h0, tx_data}, 16'h0055);
    cycle(0, 16'h0, 0, 16'h0, 16'h0, 1);

    // Push while empty with ready high, and status read during a push
    cycle(1, 16'hFF01, 1, 16'hFF00, 16'h0077, 1);
    chk("status_pre_push", rdata, 16'h0002);
    chk("push_empty", {8'h0, tx_data}, 16'h0077);
    cycle(0, 16'h0, 0, 16'h0, 16'h0, 1);

    // Unmapped access, clear, set-beats-clear, quiet I/O holes
    cycle(0, 16'h0, 1, 16'h2000, 16'hBEEF, 0);
    cycle(1, 16'h2000, 0, 16'h0, 16'h0, 0);
    chk("unmapped_rd", rdata, 16'h0000);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_unm", rdata, 16'h000A);
    cycle(0, 16'h0, 1, 16'hFF01, 16'h0008, 0);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_unm_clr", rdata, 16'h0002);
    cycle(1, 16'h1000, 1, 16'hFF01, 16'h0008, 0);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("set_beats_clr", rdata, 16'h000A);
    cycle(0, 16'h0, 1, 16'hFF01, 16'h0008, 0);
    cycle(1, 16'hFF05, 1, 16'hFF07, 16'h1234, 0);
    chk("io_hole", rdata, 16'h0000);
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("io_hole_quiet", rdata, 16'h0002);
    cycle(1, 16'h0FFF, 0, 16'h0, 16'h0, 0);

    // Cycle counter
    do_reset();
    idle(99);
    cycle(1, 16'hFF02, 0, 16'h0, 16'h0, 0);
`ifdef DMEM_CYCLE_COUNTER_EN
    chk("cnt_lo", rdata, 16'd99);
`else
    chk("cnt_lo", rdata, 16'h0000);
`endif
    cycle(1, 16'hFF03, 0, 16'h0, 16'h0, 0);
    chk("cnt_hi", rdata, 16'h0000);

    // Reset in the middle of traffic: FIFO and read data are discarded, RAM survives
    cycle(0, 16'h0, 1, 16'hFF00, 16'h0031, 0);
    cycle(0, 16'h0, 1, 16'hFF00, 16'h0032, 0);
    cycle(1, 16'h0010, 0, 16'h0, 16'h0, 0);
    do_reset();
    cycle(1, 16'hFF01, 0, 16'h0, 16'h0, 0);
    chk("status_after_rst", rdata, 16'h0002);
    cycle(1, 16'h0010, 0, 16'h0, 16'h0, 0);
    chk("ram_survives_rst", rdata, 16'h1234);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit          r, w, tr;
      logic [15:0] ra, wa, wd;
      r  = $urandom_range(0, 1);
      w  = $urandom_range(0, 1);
      tr = ($urandom_range(0, 3) == 0);
      ra = rnd_addr(0);
      wa = rnd_addr(1);
      wd = 16'($urandom);
      if (wa == 16'hFF01 && $urandom_range(0, 3) != 0) wd = wd & 16'hFFF3;
      cycle(r, ra, w, wa, wd, tr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
